star_scanner: RTL and testbench



---
 rtl/star_pkg.sv | 29 ++
 rtl/scan_addr_xlate.sv | 26 ++
 rtl/star_scanner.sv | 155 +++++++++++++++
 tb/tb_star_scanner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/star_pkg.sv
// Shared constants and FSM state type for the star scanner and the
// downstream top/bottom finder.
//   X_RES/Y_RES   : frame size in pixels
//   X_W/Y_W       : coordinate widths
//   ADDR_W        : frame RAM address width
//   COL_W         : pixel value width
//   THRESHOLD     : a pixel is lit when its value is strictly greater
//   CNT_W         : per-frame star counter width
package star_pkg;

    localparam int X_RES     = 6;
    localparam int Y_RES     = 6;
    localparam int X_W       = 3;
    localparam int Y_W       = 3;
    localparam int ADDR_W    = 6;
    localparam int COL_W     = 3;
    localparam int THRESHOLD = 0;
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EVAL,
        FOUND,
        WAIT_DONE,
        DONE
    } state_t;

endpackage

// File: rtl/scan_addr_xlate.sv
// Pixel coordinate to frame RAM address: addr = y*6 + x.
// Ports:
//   x    in  X_W     column
//   y    in  Y_W     row
//   addr out ADDR_W  linear RAM address
// The multiply by the 6-pixel row width is done as (y<<2) + (y<<1) on
// zero-extended operands; the finder stage uses this same module so both
// sides agree on the memory layout.
module scan_addr_xlate #(
    parameter int X_W    = 3,
    parameter int Y_W    = 3,
    parameter int ADDR_W = 6
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;

    assign x_ext = ADDR_W'(x);
    assign y_ext = ADDR_W'(y);
    assign addr  = (y_ext << 2) + (y_ext << 1) + x_ext;

endmodule

// File: rtl/star_scanner.sv
// Raster-scans the frame RAM for lit pixels, hands each new star to the
// top/bottom finder and skips pixels inside the box it returns.
// Ports:
//   clk, reset          clock, async active-high reset
//   start               begin a frame scan (IDLE only)
//   mem_addr, pix_val   synchronous RAM read port (1-cycle latency)
//   star_found          one-cycle pulse, new star at (star_x, star_y)
//   done_in, box_*      finder completion and the star's bounding box
//   busy                high outside IDLE
//   scan_done           one-cycle pulse at end of frame
//   star_count          stars found this frame, saturating
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | address of pixel (x,y) on mem_addr
// EVAL      | pix_val valid; decide hit / advance / finish
// FOUND     | star_found pulse to the finder
// WAIT_DONE | waiting for the finder's box
// DONE      | scan_done pulse
module star_scanner #(
    parameter int X_W       = star_pkg::X_W,
    parameter int Y_W       = star_pkg::Y_W,
    parameter int ADDR_W    = star_pkg::ADDR_W,
    parameter int COL_W     = star_pkg::COL_W,
    parameter int X_RES     = star_pkg::X_RES,
    parameter int Y_RES     = star_pkg::Y_RES,
    parameter int THRESHOLD = star_pkg::THRESHOLD,
    parameter int CNT_W     = star_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [COL_W-1:0]  pix_val,
    output logic              star_found,
    output logic [X_W-1:0]    star_x,
    output logic [Y_W-1:0]    star_y,
    input  logic              done_in,
    input  logic [Y_W-1:0]    box_top,
    input  logic [Y_W-1:0]    box_bottom,
    input  logic [X_W-1:0]    box_right,
    output logic              busy,
    output logic              scan_done,
    output logic [CNT_W-1:0]  star_count
);

    import star_pkg::*;

    state_t            state, next_state;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] addr_xlate;
    logic [ADDR_W-1:0] addr_q;
    logic              box_valid;
    logic [Y_W-1:0]    top_q, bottom_q;
    logic [X_W-1:0]    right_q;
    logic              lit, in_box, hit, last_pix, x_wrap;

    scan_addr_xlate #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) u_xlate (
        .x    (x),
        .y    (y),
        .addr (addr_xlate)
    );

    // The RAM samples the address at the end of FETCH, so the new address
    // must be visible combinationally during FETCH; it is then held.
    assign mem_addr = (state == FETCH) ? addr_xlate : addr_q;

    // star_x is the left edge of the current exclusion box.
    assign lit      = pix_val > COL_W'(THRESHOLD);
    assign in_box   = box_valid && (top_q <= y) && (y <= bottom_q)
                      && (star_x <= x) && (x <= right_q);
    assign hit      = lit && !in_box;
    assign x_wrap   = (x == X_W'(X_RES - 1));
    assign last_pix = x_wrap && (y == Y_W'(Y_RES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        star_found = 1'b0;
        scan_done  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE:      if (start) next_state = FETCH;
            FETCH:     next_state = EVAL;
            EVAL: begin
                if (hit)           next_state = FOUND;
                else if (last_pix) next_state = DONE;
                else               next_state = FETCH;
            end
            FOUND: begin
                star_found = 1'b1;
                next_state = WAIT_DONE;
            end
            WAIT_DONE: if (done_in) next_state = last_pix ? DONE : FETCH;
            DONE: begin
                scan_done  = 1'b1;
                next_state = IDLE;
            end
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            addr_q     <= '0;
            star_x     <= '0;
            star_y     <= '0;
            star_count <= '0;
            box_valid  <= 1'b0;
            top_q      <= '0;
            bottom_q   <= '0;
            right_q    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    x          <= '0;
                    y          <= '0;
                    star_count <= '0;
                    box_valid  <= 1'b0;
                end
                FETCH: addr_q <= addr_xlate;
                EVAL: begin
                    if (hit) begin
                        star_x <= x;
                        star_y <= y;
                        if (star_count != '1) star_count <= star_count + 1'b1;
                    end else if (!last_pix) begin
                        x <= x_wrap ? '0 : x + 1'b1;
                        if (x_wrap) y <= y + 1'b1;
                    end
                end
                WAIT_DONE: if (done_in) begin
                    top_q     <= box_top;
                    bottom_q  <= box_bottom;
                    right_q   <= box_right;
                    box_valid <= 1'b1;
                    if (!last_pix) begin
                        x <= x_wrap ? '0 : x + 1'b1;
                        if (x_wrap) y <= y + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_star_scanner.sv
module tb_star_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [5:0] mem_addr;
    logic [2:0] pix_val = '0;
    logic       star_found;
    logic [2:0] star_x, star_y;
    logic       done_in = 1'b0;
    logic [2:0] box_top = '0, box_bottom = '0, box_right = '0;
    logic       busy, scan_done;
    logic [3:0] star_count;

    star_scanner dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_addr   (mem_addr),
        .pix_val    (pix_val),
        .star_found (star_found),
        .star_x     (star_x),
        .star_y     (star_y),
        .done_in    (done_in),
        .box_top    (box_top),
        .box_bottom (box_bottom),
        .box_right  (box_right),
        .busy       (busy),
        .scan_done  (scan_done),
        .star_count (star_count)
    );

    always #5 clk = ~clk;

    logic [2:0] frame [64];
    always @(posedge clk) pix_val <= frame[mem_addr];

    typedef struct {
        logic [35:0] lit;     // lit pixels, bit i = pixel y*6+x
        logic [35:0] stars;   // pixels expected to be reported as stars
        logic [2:0]  pix;     // value written to lit pixels
        int          d;       // done_in this many cycles after star_found
        bit          fixed;   // reply fixed box, else single-pixel box
        logic [2:0]  top, bot, right;
        bit          early;   // also pulse done_in during FOUND (ignored)
    } vec_t;

    typedef struct { int x; int y; int cyc; } exp_t;

    exp_t exp_q[$];
    vec_t vecs[7];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [35:0] bit_of(input int i);
        logic [35:0] one;
        one = 36'd1;
        return one << i;
    endfunction

    task automatic load_frame(input vec_t v);
        for (int i = 0; i < 64; i++) frame[i] = '0;
        for (int i = 0; i < 36; i++) if (v.lit[i]) frame[i] = v.pix;
    endtask

    task automatic run_frame(input vec_t v, input int restart_cyc, input string tag);
        int   cyc, fcyc, nstars, exp_done, exp_cnt, rx, ry;
        bit   done_seen;
        exp_t e;
        load_frame(v);
        exp_q.delete();
        nstars = 0;
        for (int i = 0; i < 36; i++) begin
            if (v.stars[i]) begin
                e.x = i % 6; e.y = i / 6; e.cyc = 2 * i + 3 + nstars * (1 + v.d);
                exp_q.push_back(e);
                nstars++;
            end
        end
        exp_done  = 73 + nstars * (1 + v.d);
        exp_cnt   = (nstars > 15) ? 15 : nstars;
        fcyc      = -1;
        rx        = 0;
        ry        = 0;
        done_seen = 1'b0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        chk({tag, " first fetch addr"}, int'(mem_addr), 0);
        chk({tag, " busy after start"}, int'(busy), 1);
        while (!done_seen && cyc < 400) begin
            if (star_found) begin
                if (exp_q.size() == 0) begin
                    chk({tag, " unexpected star_found cycle"}, cyc, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, " star_x"}, int'(star_x), e.x);
                    chk({tag, " star_y"}, int'(star_y), e.y);
                    chk({tag, " star_found cycle"}, cyc, e.cyc);
                    rx = e.x; ry = e.y;
                end
                fcyc = cyc;
            end
            done_in = (fcyc >= 0) && (cyc == fcyc + v.d || (v.early && cyc == fcyc));
            if (v.fixed) begin
                box_top = v.top; box_bottom = v.bot; box_right = v.right;
            end else begin
                box_top = 3'(ry); box_bottom = 3'(ry); box_right = 3'(rx);
            end
            if (fcyc >= 0 && cyc == fcyc + v.d) fcyc = -1;
            start = (cyc == restart_cyc);
            if (scan_done) begin
                done_seen = 1'b1;
                chk({tag, " scan_done cycle"}, cyc, exp_done);
                chk({tag, " star_count"}, int'(star_count), exp_cnt);
            end
            @(posedge clk);
            #1 cyc++;
        end
        done_in = 1'b0;
        start   = 1'b0;
        if (!done_seen) chk({tag, " scan_done timeout"}, 0, 1);
        chk({tag, " busy after done"}, int'(busy), 0);
        chk({tag, " scan_done one pulse"}, int'(scan_done), 0);
        chk({tag, " star_count held"}, int'(star_count), exp_cnt);
        chk({tag, " last fetch addr held"}, int'(mem_addr), 35);
        chk({tag, " stars left in queue"}, exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{lit: '0, stars: '0, pix: 3'd1, d: 1, fixed: 1'b0,
                    top: '0, bot: '0, right: '0, early: 1'b0};
        vecs[1] = '{lit: bit_of(8), stars: bit_of(8), pix: 3'd7, d: 3, fixed: 1'b1,
                    top: 3'd1, bot: 3'd1, right: 3'd3, early: 1'b0};
        vecs[2] = '{lit: bit_of(15) | bit_of(16) | bit_of(21) | bit_of(22),
                    stars: bit_of(15), pix: 3'd4, d: 2, fixed: 1'b1,
                    top: 3'd2, bot: 3'd3, right: 3'd5, early: 1'b1};
        vecs[3] = '{lit: bit_of(35), stars: bit_of(35), pix: 3'd2, d: 1, fixed: 1'b0,
                    top: '0, bot: '0, right: '0, early: 1'b0};
        // (1,1) is inside the replacement box whose left edge is the newer star (0,1)
        vecs[4] = '{lit: bit_of(1) | bit_of(6) | bit_of(7), stars: bit_of(1) | bit_of(6),
                    pix: 3'd5, d: 1, fixed: 1'b1, top: 3'd0, bot: 3'd1, right: 3'd1,
                    early: 1'b0};
        vecs[5] = '{lit: 36'h0_0000_FFFF, stars: 36'h0_0000_FFFF, pix: 3'd3, d: 1,
                    fixed: 1'b0, top: '0, bot: '0, right: '0, early: 1'b0};
        vecs[6] = '{lit: bit_of(5) | bit_of(11), stars: bit_of(5), pix: 3'd1, d: 1,
                    fixed: 1'b1, top: 3'd0, bot: 3'd1, right: 3'd6, early: 1'b0};
        for (int i = 0; i < 64; i++) frame[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset star_found", int'(star_found), 0);
        chk("reset mem_addr", int'(mem_addr), 0);
        chk("reset star_count", int'(star_count), 0);
        chk("reset star_xy", int'({star_x, star_y}), 0);
        @(negedge clk) reset = 1'b0;

        run_frame(vecs[0], -1, "blank");
        run_frame(vecs[1], -1, "single");
        run_frame(vecs[2], -1, "blob");
        run_frame(vecs[3], -1, "last_pixel");
        run_frame(vecs[4], -1, "box_replace");
        run_frame(vecs[5], -1, "saturate");
        run_frame(vecs[6], -1, "right_edge");

        // reset while waiting for the finder
        begin
            int   n;
            vec_t v;
            v = vecs[1];
            load_frame(v);
            @(negedge clk) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            n = 0;
            while (!star_found && n < 100) begin
                @(posedge clk);
                #1 n++;
            end
            chk("rst_wait star_found seen", int'(star_found), 1);
            @(posedge clk);
            #2 reset = 1'b1;
            #1;
            chk("rst_wait busy", int'(busy), 0);
            chk("rst_wait star_x", int'(star_x), 0);
            chk("rst_wait star_y", int'(star_y), 0);
            chk("rst_wait star_count", int'(star_count), 0);
            chk("rst_wait mem_addr", int'(mem_addr), 0);
            chk("rst_wait flags", int'({star_found, scan_done}), 0);
            @(negedge clk) reset = 1'b0;
        end
        run_frame(vecs[1], -1, "after_reset");

        // start pulsed during the first FETCH must be ignored
        run_frame(vecs[0], 1, "start_in_fetch");
        run_frame(vecs[3], 1, "start_in_fetch_star");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
